// File: rtl/calc_acc.sv
// rtl/calc_acc.sv - calculator accumulator with debounced execute and clear buttons
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   btnc    raw execute button
//   btnac   raw clear button
//   alu_op  4-bit operation code from the button encoder
//   sw      16-bit operand B
//   led     accumulator value
//   ovf     signed overflow of the last committed ADD/SUB
//   err     last committed code was undefined
//   busy    FSM not in IDLE
//   done    one-cycle pulse the cycle after a commit

module calc_acc #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnc,
  input  logic        btnac,
  input  logic [3:0]  alu_op,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        ovf,
  output logic        err,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    EXC  = 2'd2,
    HLD  = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        btnc_q;
  logic        btnc_s;
  logic        btnac_q;
  logic        btnac_s;
  logic [15:0] acc;
  logic [15:0] res;
  logic [15:0] sum;
  logic [15:0] diff;
  logic        ovf_nxt;
  logic        err_nxt;

  // Two-flop synchronizers for the raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnc_q  <= 1'b0;
      btnc_s  <= 1'b0;
      btnac_q <= 1'b0;
      btnac_s <= 1'b0;
    end else begin
      btnc_q  <= btnc;
      btnc_s  <= btnc_q;
      btnac_q <= btnac;
      btnac_s <= btnac_q;
    end
  end

  // State register; clear forces IDLE from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (btnac_s) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (btnc_s) state_nxt = DEB;
      DEB: begin
        if (!btnc_s) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = EXC;
        end
      end
      EXC:     state_nxt = HLD;
      HLD:     if (!btnc_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state != IDLE);
    led  = acc;
  end

  // Debounce counter: held at 0 in IDLE so DEB always starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (btnac_s || state == IDLE) begin
      cnt <= 8'd0;
    end else if (state == DEB && btnc_s && cnt != DEB_LAST) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign sum  = acc + sw;
  assign diff = acc - sw;

  // Operation decode and result.
  always_comb begin
    res     = acc;
    ovf_nxt = 1'b0;
    err_nxt = 1'b0;
    case (alu_op)
      4'b0000: res = acc & sw;
      4'b0001: res = acc | sw;
      4'b0100: begin
        res     = sum;
        ovf_nxt = (acc[15] == sw[15]) && (sum[15] != acc[15]);
      end
      4'b0101: begin
        res     = diff;
        ovf_nxt = (acc[15] != sw[15]) && (diff[15] != acc[15]);
      end
      4'b0110: res = acc ^ sw;
      4'b1010: res = acc << sw[3:0];
      4'b1011: res = acc >> sw[3:0];
      4'b1100: res = $signed(acc) >>> sw[3:0];
      default: err_nxt = 1'b1;
    endcase
  end

  // Accumulator and flags; clear beats a coincident EXC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= 16'h0000;
      ovf  <= 1'b0;
      err  <= 1'b0;
      done <= 1'b0;
    end else if (btnac_s) begin
      acc  <= 16'h0000;
      ovf  <= 1'b0;
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == EXC);
      if (state == EXC) begin
        acc <= res;
        ovf <= ovf_nxt;
        err <= err_nxt;
      end
    end
  end

endmodule

// File: doc/calc_acc.md
# calc_acc

Accumulator and control back-end of the calculator: consumes the 4-bit `alu_op` code produced by the button encoder, decodes it into one of eight operations, and applies it between a 16-bit accumulator and the switch operand. Each operation is triggered by one debounced press of the centre button. The accumulator drives the LEDs directly.

## Interface
- `DEB_CYCLES`, default 4: number of consecutive cycles the synchronized `btnc` must stay high before an operation commits. Legal range is 1..255.
- `clk`: input, 1 bit. System clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `btnc`: input, 1 bit. Execute button, raw and asynchronous.
- `btnac`: input, 1 bit. Clear button, raw and asynchronous.
- `alu_op`: input, 4 bits. Operation code from the encoder.
- `sw`: input, 16 bits. Operand B.
- `led`: output, 16 bits. Accumulator value.
- `ovf`: output, 1 bit. Signed overflow of the last committed ADD or SUB.
- `err`: output, 1 bit. Last committed code was undefined.
- `busy`: output, 1 bit. High when the FSM is not in IDLE.
- `done`: output, 1 bit. One-cycle pulse, high the cycle after an operation commits.

## Operation
- **Input synchronizers.** `btnc` and `btnac` each pass through 2 flip-flops, giving `btnc_s` and `btnac_s`. Only the synchronized versions are used. Both synchronizers reset to 0.
- **Decode of `alu_op`.** Let A be the accumulator and B be `sw`.
  - 0000: AND. A & B.
  - 0001: OR. A | B.
  - 0100: ADD. A + B, modulo 2^16.
  - 0101: SUB. A − B, modulo 2^16.
  - 0110: XOR. A ^ B.
  - 1010: SLL. A << B[3:0].
  - 1011: SRL. A >> B[3:0], logical.
  - 1100: SRA. A >>> B[3:0], arithmetic (sign-filling).
  - Any other code: A is unchanged and `err` is set to 1.
- **Overflow (`ovf`).**
  - ADD: `ovf` is 1 when A and B have the same sign and the result's sign differs.
  - SUB: `ovf` is 1 when A and B have different signs and the result's sign differs from A.
  - Any other defined code: `ovf` is 0.
  - `ovf` and `err` are registered. They are updated only on commit and hold their value otherwise.
- **FSM states.**
  - IDLE: if `btnc_s`=1, go to DEB and set the counter to 0.
  - DEB: if `btnc_s`=0, go to IDLE (glitch rejected). Otherwise, if the counter equals DEB_CYCLES−1, go to EXC; if not, increment the counter.
  - EXC: lasts 1 cycle. `alu_op` and `sw` are sampled in this cycle. A, `ovf` and `err` load at the closing edge. Then go to HLD.
  - HLD: stay until `btnc_s`=0, then go to IDLE. Exactly one commit happens per press, however long the button is held.
- **Clear.** While `btnac_s`=1:
  - A, `ovf`, `err` and the counter are cleared to 0 and the state is forced to IDLE.
  - Clear has priority over every state, including EXC; the op in progress is discarded.
  - If `btnc_s` is still high when clear releases, a new debounce starts from IDLE.
- **Reset.** `rst_n`=0 clears everything asynchronously, mid-operation included:
  - state=IDLE, counter=0, `led`=0x0000, `ovf`=0, `err`=0, `busy`=0, `done`=0.
- **Output definitions.**
  - `busy` is combinational: (state != IDLE).
  - `done` is registered: 1 in the cycle after EXC, otherwise 0.

## Timing
- **Commit latency.** `btnc` high sampled at edge 0 gives:
  - `btnc_s`=1 after edge 1.
  - DEB entered after edge 2.
  - EXC after edge 2+DEB_CYCLES.
  - `led`, `ovf`, `err` and `done` update at edge 3+DEB_CYCLES. With the default DEB_CYCLES=4, that is edge 7.
- **Minimum press.** `btnc` must be high for at least DEB_CYCLES+1 consecutive sampled cycles to commit.
- **Clear latency.** `btnac` high sampled at edge 0 gives `btnac_s`=1 after edge 1 and `led`=0 after edge 2.
- **Clear vs. execute.** If `btnac_s` and EXC coincide, the clear wins: `led`=0 and `done` stays 0.
- **Operand timing.** `alu_op` and `sw` may change at any time; only the EXC-cycle values matter.
- **Repeat presses.** A second press requires `btnc_s` to fall back to 0 first, so it is at least 1 IDLE cycle after HLD.

## Test plan
- **Reset and ADD commit.** Reset, then `sw`=0x0003, `alu_op`=0100, hold `btnc` for 10 cycles. Required: `led`=0x0003 at edge 7, `done` high for exactly 1 cycle, and `led` unchanged while `btnc` stays held.
- **Signed overflow.** Reach A=0x7FFF, then ADD with `sw`=0x0001. Required: `led`=0x8000, `ovf`=1. Then SUB with `sw`=0x0001 gives `led`=0x7FFF, `ovf`=1. Then OR with 0x0000 gives `ovf`=0.
- **Shifts.** With A=0x8001 and `sw`=0x0004:
  - SRA gives `led`=0xF800.
  - Reload A=0x8001; SRL gives 0x0800.
  - Reload A=0x8001; SLL gives 0x0010.
- **Undefined code.** With A=0x1234, press with `alu_op`=0011. Required: `led`=0x1234, `err`=1. The next valid op clears `err` to 0.
- **Glitch rejection.** Pulse `btnc` high for DEB_CYCLES−1 sampled cycles. Required: `busy` rises then returns to 0, and `done` never asserts with `led` unchanged.
- **Clear and reset mid-operation.**
  - Assert `btnac` while in DEB. Required: `led`=0, `ovf`=`err`=0, state IDLE.
  - Separately, drop `rst_n` in HLD. Required: all outputs immediately 0.
